// File: rtl/regw_arbiter.sv
// Round-robin write-ownership arbiter in front of one shared WIDTH-bit register.
// Optional hold-limit preemption is enabled with `define REGW_ARB_PREEMPT_EN.
module regw_arbiter #(
  parameter int NREQ     = 4,
  parameter int WIDTH    = 8,
  parameter int IDXW     = 2,
  parameter int MAX_HOLD = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] wdata,
  output logic [NREQ-1:0]       gnt,
  output logic [WIDTH-1:0]      q,
  output logic [IDXW-1:0]       owner,
  output logic                  busy,
  output logic                  state_dbg,
  output logic [IDXW-1:0]       ptr_dbg
);

  // Handshake: a requester raises req and holds it; gnt (registered, one-hot)
  // answers one cycle later; every cycle with gnt[i] && req[i] is a write of
  // slice i; dropping req releases ownership on that edge without writing.

  localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HW-1:0] HOLD_MAX = HW'(MAX_HOLD - 1);

  typedef enum logic {IDLE = 1'b0, OWN = 1'b1} state_t;

  state_t            state, state_nxt;
  logic [IDXW-1:0]   ptr;
  logic [HW-1:0]     hold_cnt;
  logic [IDXW-1:0]   sel;
  logic              sel_vld;
  logic [NREQ-1:0]   sel_oh;
  logic [IDXW-1:0]   owner_inc;
  logic              wr_en;
  logic              preempt;
  logic [WIDTH-1:0]  wslice [NREQ];

  for (genvar g = 0; g < NREQ; g++) begin : g_slice
    assign wslice[g] = wdata[g*WIDTH +: WIDTH];
  end

  // Scan from ptr downward in reverse so the candidate closest to ptr wins.
  always_comb begin
    int cand;
    cand    = 0;
    sel     = '0;
    sel_vld = 1'b0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      cand = int'(ptr) + i;
      if (cand >= NREQ) cand = cand - NREQ;
      if (req[IDXW'(cand)]) begin
        sel     = IDXW'(cand);
        sel_vld = 1'b1;
      end
    end
  end

  always_comb begin
    sel_oh      = '0;
    sel_oh[sel] = 1'b1;
  end

  assign owner_inc = (owner == IDXW'(NREQ - 1)) ? '0 : owner + IDXW'(1);
  assign wr_en     = (state == OWN) && gnt[owner] && req[owner];

`ifdef REGW_ARB_PREEMPT_EN
  logic [NREQ-1:0] others;
  always_comb begin
    others        = req;
    others[owner] = 1'b0;
  end
  assign preempt = wr_en && (hold_cnt == HOLD_MAX) && (|others);
`else
  assign preempt = 1'b0;
`endif

  // State register plus the registered datapath (grant, owner, ptr, storage).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      gnt      <= '0;
      q        <= '0;
      owner    <= '0;
      ptr      <= '0;
      hold_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (wr_en) q <= wslice[owner];
      case (state)
        IDLE: begin
          if (sel_vld) begin
            owner    <= sel;
            gnt      <= sel_oh;
            hold_cnt <= '0;
          end
        end
        OWN: begin
          if (wr_en && (hold_cnt != HOLD_MAX)) hold_cnt <= hold_cnt + HW'(1);
          if (state_nxt == IDLE) begin
            gnt <= '0;
            ptr <= owner_inc;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (sel_vld) state_nxt = OWN;
      OWN:     if (!req[owner] || preempt) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state == OWN);
    state_dbg = state;
    ptr_dbg   = ptr;
  end

endmodule

// File: tb/tb_regw_arbiter.sv
// Scoreboard bench for regw_arbiter: expected grants and register values are
// queued as stimulus is issued and popped by a monitor on observed changes.
module tb_regw_arbiter;

  localparam int NREQ  = 4;
  localparam int WIDTH = 8;
  localparam int IDXW  = 2;

  logic                  clk;
  logic                  rst_n;
  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] wdata;
  logic [NREQ-1:0]       gnt;
  logic [WIDTH-1:0]      q;
  logic [IDXW-1:0]       owner;
  logic                  busy;
  logic                  state_dbg;
  logic [IDXW-1:0]       ptr_dbg;

  logic [NREQ-1:0]  exp_gnt_q[$];
  logic [WIDTH-1:0] exp_q[$];
  logic [NREQ-1:0]  prev_gnt;
  logic [WIDTH-1:0] prev_q;
  logic             mon_en;
  int               n_vec;
  int               n_err;

  regw_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .IDXW(IDXW), .MAX_HOLD(4)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .wdata(wdata), .gnt(gnt), .q(q),
    .owner(owner), .busy(busy), .state_dbg(state_dbg), .ptr_dbg(ptr_dbg)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_wd(input int i, input logic [WIDTH-1:0] v);
    wdata[i*WIDTH +: WIDTH] = v;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (mon_en) begin
      if (gnt !== prev_gnt && gnt !== '0) begin
        if (exp_gnt_q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL gnt_unexpected: got %b, expected no grant", gnt);
        end else begin
          chk("sb_gnt", 32'(gnt), 32'(exp_gnt_q.pop_front()));
        end
      end
      if (q !== prev_q) begin
        if (exp_q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL q_unexpected: got %h, expected no change", q);
        end else begin
          chk("sb_q", 32'(q), 32'(exp_q.pop_front()));
        end
      end
    end
    prev_gnt <= gnt;
    prev_q   <= q;
  end

  initial begin
    n_vec  = 0;
    n_err  = 0;
    mon_en = 1'b0;
    rst_n  = 1'b0;
    req    = 4'b1111;
    wdata  = '0;

    // Reset held for two edges with all requests up
    tick();
    tick();
    mon_en = 1'b1;
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_q", 32'(q), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_owner", 32'(owner), 32'h0);
    chk("rst_state", 32'(state_dbg), 32'h0);
    exp_gnt_q.push_back(4'b0001);
    rst_n = 1'b1;
    tick();
    chk("first_gnt", 32'(gnt), 32'h1);
    req = '0;
    tick();
    chk("first_release_busy", 32'(busy), 32'h0);

    // Single requester 2
    req = 4'b0100;
    set_wd(2, 8'hA5);
    exp_gnt_q.push_back(4'b0100);
    exp_q.push_back(8'hA5);
    tick();
    chk("single_gnt", 32'(gnt), 32'h4);
    chk("single_q_pre", 32'(q), 32'h0);
    tick();
    chk("single_q", 32'(q), 32'hA5);
    tick();
    chk("single_busy_hold", 32'(busy), 32'h1);
    req = '0;
    tick();
    chk("single_busy_fall", 32'(busy), 32'h0);
    chk("single_ptr", 32'(ptr_dbg), 32'h3);

    // Round robin from ptr=0
    exp_q.push_back(8'h00);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < NREQ; i++) set_wd(i, 8'(8'h10 * (i + 1)));
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      int o;
      o = k % NREQ;
      exp_gnt_q.push_back(4'(1 << o));
      exp_q.push_back(8'(8'h10 * (o + 1)));
      tick();
      chk("rr_gnt", 32'(gnt), 32'(1 << o));
      tick();
      req[o] = 1'b0;
      tick();
      chk("rr_idle_gap", 32'(busy), 32'h0);
      req[o] = 1'b1;
    end
    req = '0;
    tick();

    // Contention: owner 1 bursts while requester 0 waits
    req = 4'b0010;
    set_wd(1, 8'h11);
    exp_gnt_q.push_back(4'b0010);
    exp_q.push_back(8'h11);
    exp_q.push_back(8'h22);
    tick();
    tick();
    req[0] = 1'b1;
    set_wd(1, 8'h22);
    tick();
    chk("cont_no_gnt0_a", 32'(gnt), 32'h2);
    tick();
    chk("cont_no_gnt0_b", 32'(gnt), 32'h2);
    req[1] = 1'b0;
    set_wd(0, 8'h33);
    exp_gnt_q.push_back(4'b0001);
    exp_q.push_back(8'h33);
    tick();
    chk("cont_release_gnt", 32'(gnt), 32'h0);
    chk("cont_final_q", 32'(q), 32'h22);
    tick();
    chk("cont_gnt0", 32'(gnt), 32'h1);
    tick();
    req = '0;
    tick();

    // Hold limit: owner 0 writes 1..6 while requester 3 waits
    exp_q.push_back(8'h00);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    set_wd(3, 8'h77);
    req = 4'b1001;
    exp_gnt_q.push_back(4'b0001);
    for (int i = 1; i <= 4; i++) exp_q.push_back(8'(i));
`ifdef REGW_ARB_PREEMPT_EN
    exp_gnt_q.push_back(4'b1000);
    exp_q.push_back(8'h77);
`else
    exp_q.push_back(8'h05);
    exp_q.push_back(8'h06);
`endif
    tick();
    for (int i = 1; i <= 6; i++) begin
      set_wd(0, 8'(i));
      tick();
`ifdef REGW_ARB_PREEMPT_EN
      if (i == 4) begin
        chk("pre_q4", 32'(q), 32'h04);
        chk("pre_idle", 32'(busy), 32'h0);
      end
      if (i == 5) chk("pre_gnt3", 32'(gnt), 32'h8);
`endif
    end
`ifndef REGW_ARB_PREEMPT_EN
    chk("hold_q6", 32'(q), 32'h06);
    chk("hold_gnt0", 32'(gnt), 32'h1);
`endif
    req = '0;
    tick();

    // Reset in the middle of owner 2's burst
    req = 4'b0100;
    set_wd(2, 8'hFF);
    exp_gnt_q.push_back(4'b0100);
    exp_q.push_back(8'hFF);
    exp_q.push_back(8'h00);
    tick();
    tick();
    chk("mid_q_ff", 32'(q), 32'hFF);
    rst_n = 1'b0;
    req = 4'b1111;
    tick();
    chk("mid_rst_q", 32'(q), 32'h0);
    chk("mid_rst_gnt", 32'(gnt), 32'h0);
    chk("mid_rst_busy", 32'(busy), 32'h0);
    chk("mid_rst_ptr", 32'(ptr_dbg), 32'h0);
    rst_n = 1'b1;
    exp_gnt_q.push_back(4'b0001);
    tick();
    chk("mid_restart_gnt", 32'(gnt), 32'h1);
    req = '0;
    tick();

    // Drain with a bounded wait, then flag anything still expected
    for (int i = 0; i < 20 && (exp_gnt_q.size() != 0 || exp_q.size() != 0); i++) tick();
    while (exp_gnt_q.size() != 0) begin
      n_vec++; n_err++;
      $display("FAIL gnt_missing: got none, expected %b", exp_gnt_q.pop_front());
    end
    while (exp_q.size() != 0) begin
      n_vec++; n_err++;
      $display("FAIL q_missing: got none, expected %h", exp_q.pop_front());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
